// File: rtl/xsm_pkg.sv
// Shared types for the XSM capture sequencer.
//   xsm_seq_state_e : sequencer state encoding
//   xsm_sample_t    : one buffered beat {data, ts, last}
//   SAMPLE_W, TS_W  : default sample and timestamp widths
package xsm_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned TS_W     = 48;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        BURST,
        DRAIN,
        HOLDOFF
    } xsm_seq_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic [TS_W-1:0]     ts;
        logic                last;
    } xsm_sample_t;

endpackage

// File: rtl/xsm_skid_fifo2.sv
// Two-entry valid/ready FIFO of xsm_sample_t. The outputs come straight from
// the head register, so the downstream path has no combinational input.
//   clk, rst_n      : clock, async active-low reset
//   flush           : drop both entries (takes priority over push/pop)
//   push, din       : write one entry; only legal while in_ready
//   set_tail_last   : set the last bit of the tail entry (dropped-last case)
//   in_ready        : room for a push this clk (full but popping counts)
//   out_valid/out_ready/dout : downstream stream
module xsm_skid_fifo2
    import xsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  xsm_sample_t din,
    input  logic        set_tail_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output xsm_sample_t dout
);

    xsm_sample_t head_q;
    xsm_sample_t tail_q;
    logic        head_v;
    logic        tail_v;
    logic        pop;

    assign pop       = head_v & out_ready;
    // tail_v implies head_v, so a full FIFO that pops still has a free slot
    assign in_ready  = ~tail_v | pop;
    assign out_valid = head_v;
    assign dout      = head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (flush) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (pop) begin
            if (tail_v) begin
                head_q <= tail_q;
                tail_q <= din;
                tail_v <= push;
            end else begin
                head_q <= din;
                head_v <= push;
            end
        end else if (push) begin
            if (!head_v) begin
                head_q <= din;
                head_v <= 1'b1;
            end else if (!tail_v) begin
                tail_q <= din;
                tail_v <= 1'b1;
            end
        end else if (set_tail_last && tail_v) begin
            tail_q.last <= 1'b1;
        end
    end

endmodule

// File: rtl/xsm_capture_seq.sv
// XSM single-ADC capture sequencer: arm, qualify a trigger rising edge, wait a
// post-trigger delay, then capture a decimated burst of timestamped samples
// into a 2-entry output FIFO, drain it, and hold off before re-arming/idling.
//   clk, rst_n                         : clock, async active-low reset
//   cfg_arm/cfg_abort/cfg_rearm        : run control
//   cfg_delay/count/decim/holdoff      : run config, shadowed on the arm clk
//   trigger_in, vin_adc, mono_counter  : trigger, ADC sample, timestamp
//   out_valid/ready/data/ts/last       : sample stream
//   st_armed/busy/done/overflow        : status
module xsm_capture_seq
    import xsm_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = xsm_pkg::SAMPLE_W,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TS_W         = xsm_pkg::TS_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_arm,
    input  logic                    cfg_abort,
    input  logic                    cfg_rearm,
    input  logic [CNT_W-1:0]        cfg_delay,
    input  logic [CNT_W-1:0]        cfg_count,
    input  logic [7:0]              cfg_decim,
    input  logic [CNT_W-1:0]        cfg_holdoff,
    input  logic                    trigger_in,
    input  logic [SAMPLE_WIDTH-1:0] vin_adc,
    input  logic [TS_W-1:0]         mono_counter,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic [TS_W-1:0]         out_ts,
    output logic                    out_last,
    output logic                    st_armed,
    output logic                    st_busy,
    output logic                    st_done,
    output logic                    st_overflow
);

    xsm_seq_state_e state, state_nx;

    logic             trig_q;
    logic [CNT_W-1:0] dcnt, scnt, hcnt;
    logic [CNT_W-1:0] sh_delay, sh_count, sh_holdoff;
    logic [7:0]       sh_decim, phase;
    logic             st_done_q, st_overflow_q;

    logic        trig_edge, arm_go, capture, cap_last;
    logic        fifo_in_ready, fifo_push, fifo_drop, fifo_pop;
    xsm_sample_t cap_sample, head;

    assign trig_edge = trigger_in & ~trig_q;
    assign arm_go    = (state == IDLE) & cfg_arm & ~cfg_abort;
    assign capture   = (state == BURST) & (phase == sh_decim) & ~cfg_abort;
    assign cap_last  = capture & (scnt == CNT_W'(1));
    assign fifo_push = capture & fifo_in_ready;
    assign fifo_drop = capture & ~fifo_in_ready;
    assign fifo_pop  = out_valid & out_ready;

    always_comb begin
        cap_sample      = '0;
        cap_sample.data = vin_adc;
        cap_sample.ts   = mono_counter;
        cap_sample.last = cap_last;
    end

    xsm_skid_fifo2 u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (cfg_abort),
        .push          (fifo_push),
        .din           (cap_sample),
        .set_tail_last (fifo_drop & cap_last),
        .in_ready      (fifo_in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dout          (head)
    );

    assign out_data    = head.data;
    assign out_ts      = head.ts;
    assign out_last    = head.last;
    assign st_armed    = (state == ARMED);
    assign st_busy     = (state != IDLE) && (state != ARMED);
    assign st_done     = st_done_q;
    assign st_overflow = st_overflow_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cfg_arm) state_nx = ARMED;
            ARMED:   if (trig_edge) state_nx = (sh_delay == '0) ? BURST : DELAY;
            DELAY:   if (dcnt <= CNT_W'(1)) state_nx = BURST;
            BURST:   if (cap_last) state_nx = DRAIN;
            DRAIN:   if (!out_valid) state_nx = HOLDOFF;
            // holdoff of 0 or 1 both leave after a single HOLDOFF clk
            HOLDOFF: if (hcnt <= CNT_W'(1)) state_nx = cfg_rearm ? ARMED : IDLE;
            default: state_nx = IDLE;
        endcase
        if (cfg_abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            trig_q        <= 1'b0;
            dcnt          <= '0;
            scnt          <= '0;
            hcnt          <= '0;
            phase         <= '0;
            sh_delay      <= '0;
            sh_count      <= '0;
            sh_decim      <= '0;
            sh_holdoff    <= '0;
            st_done_q     <= 1'b0;
            st_overflow_q <= 1'b0;
        end else begin
            state     <= state_nx;
            trig_q    <= trigger_in;
            st_done_q <= fifo_pop & head.last & ~cfg_abort;

            if (fifo_drop) begin
                st_overflow_q <= 1'b1;
            end else if (arm_go) begin
                st_overflow_q <= 1'b0;
            end

            if (!cfg_abort) begin
                unique case (state)
                    IDLE: if (cfg_arm) begin
                        sh_delay   <= cfg_delay;
                        sh_count   <= cfg_count;
                        sh_decim   <= cfg_decim;
                        sh_holdoff <= cfg_holdoff;
                    end
                    ARMED: if (trig_edge) begin
                        dcnt  <= sh_delay;
                        scnt  <= (sh_count == '0) ? CNT_W'(1) : sh_count;
                        // preload so the first BURST clk captures
                        phase <= sh_decim;
                    end
                    DELAY: dcnt <= dcnt - CNT_W'(1);
                    BURST: begin
                        if (phase == sh_decim) begin
                            phase <= '0;
                            scnt  <= scnt - CNT_W'(1);
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                    DRAIN: if (!out_valid) hcnt <= sh_holdoff;
                    HOLDOFF: if (hcnt != '0) hcnt <= hcnt - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xsm_capture_seq.sv
module tb_xsm_capture_seq;

    localparam int SW = 16;
    localparam int CW = 16;
    localparam int TW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_rearm = 1'b0;
    logic [CW-1:0] cfg_delay = '0, cfg_count = '0, cfg_holdoff = '0;
    logic [7:0]    cfg_decim = '0;
    logic          trigger_in = 1'b0;
    logic [SW-1:0] vin_adc;
    logic [TW-1:0] mono = '0;
    logic          out_valid, out_ready = 1'b1, out_last;
    logic [SW-1:0] out_data;
    logic [TW-1:0] out_ts;
    logic          st_armed, st_busy, st_done, st_overflow;

    xsm_capture_seq #(.SAMPLE_WIDTH(SW), .CNT_W(CW), .TS_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_rearm(cfg_rearm),
        .cfg_delay(cfg_delay), .cfg_count(cfg_count), .cfg_decim(cfg_decim),
        .cfg_holdoff(cfg_holdoff), .trigger_in(trigger_in),
        .vin_adc(vin_adc), .mono_counter(mono),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ts(out_ts), .out_last(out_last),
        .st_armed(st_armed), .st_busy(st_busy), .st_done(st_done),
        .st_overflow(st_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mono <= mono + 1'b1;
    assign vin_adc = mono[15:0] ^ 16'hA5A5;

    int tests = 0;
    int fails = 0;

    // accepted beats and st_done pulses, observed mid-cycle
    logic [TW-1:0] q_ts[$];
    logic [SW-1:0] q_data[$];
    bit            q_last[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_ts.push_back(out_ts);
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (st_done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 0);
        check({tag, " out_data"}, 64'(out_data), 0);
        check({tag, " out_ts"}, 64'(out_ts), 0);
        check({tag, " out_last"}, 64'(out_last), 0);
        check({tag, " st_armed"}, 64'(st_armed), 0);
        check({tag, " st_busy"}, 64'(st_busy), 0);
        check({tag, " st_done"}, 64'(st_done), 0);
        check({tag, " st_overflow"}, 64'(st_overflow), 0);
    endtask

    typedef struct {
        int delay;
        int count;
        int decim;
        bit hold_ready;   // out_ready low for the burst, released afterwards
        int exp_beats;
        int exp_off;      // first ts minus ts of the trigger clk
        int exp_sp;       // ts spacing between beats
        bit exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic arm_and_trigger(output logic [TW-1:0] t0);
        cfg_arm = 1'b1;
        step();
        cfg_arm = 1'b0;
        check("armed after cfg_arm", 64'(st_armed), 1);
        trigger_in = 1'b0;
        step();
        trigger_in = 1'b1;
        t0 = mono;          // mono value sampled on the edge clk
        step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int b0, d0, n, got;
        logic [TW-1:0] t0, ets;
        b0 = q_ts.size();
        d0 = done_cnt;
        cfg_delay   = CW'(v.delay);
        cfg_count   = CW'(v.count);
        cfg_decim   = 8'(v.decim);
        cfg_holdoff = '0;
        cfg_rearm   = 1'b0;
        out_ready   = !v.hold_ready;
        arm_and_trigger(t0);
        trigger_in = 1'b0;
        n = 0;
        while ((st_busy || st_armed) && n < 300) begin
            if (n == 20) out_ready = 1'b1;
            step();
            n++;
        end
        check({tag, " finished in budget"}, 64'(n < 300), 1);
        out_ready = 1'b1;
        step(2);
        got = q_ts.size() - b0;
        check({tag, " beats"}, 64'(got), 64'(v.exp_beats));
        for (int i = 0; i < v.exp_beats && i < got; i++) begin
            ets = t0 + TW'(v.exp_off + i * v.exp_sp);
            check($sformatf("%s beat%0d ts", tag, i), 64'(q_ts[b0+i]), 64'(ets));
            check($sformatf("%s beat%0d data", tag, i), 64'(q_data[b0+i]), 64'(ets[15:0] ^ 16'hA5A5));
            check($sformatf("%s beat%0d last", tag, i), 64'(q_last[b0+i]), 64'(i == v.exp_beats - 1));
        end
        check({tag, " st_done pulses"}, 64'(done_cnt - d0), 1);
        check({tag, " st_overflow"}, 64'(st_overflow), 64'(v.exp_ovf));
    endtask

    initial begin
        int b0, d0, k;
        logic [TW-1:0] t0;

        //            dly cnt dec hold beats off sp ovf
        vecs[0] = '{3, 4, 0, 0, 4, 4, 1, 0};
        vecs[1] = '{0, 2, 0, 0, 2, 1, 1, 0};
        vecs[2] = '{1, 3, 2, 0, 3, 2, 3, 0};
        vecs[3] = '{2, 0, 0, 0, 1, 3, 1, 0};
        vecs[4] = '{3, 4, 0, 1, 2, 4, 1, 1};
        vecs[5] = '{5, 5, 1, 0, 5, 6, 2, 0};

        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        step(2);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 4) begin
                cfg_abort = 1'b1;
                step();
                cfg_abort = 1'b0;
                check("overflow survives abort", 64'(st_overflow), 1);
            end
        end

        // simultaneous arm and abort stays idle
        cfg_arm = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_arm = 1'b0;
        cfg_abort = 1'b0;
        check("arm+abort armed", 64'(st_armed), 0);
        check("arm+abort busy", 64'(st_busy), 0);

        // rearm with holdoff 5; trigger held high must not retrigger
        cfg_delay = '0; cfg_count = 16'd2; cfg_decim = '0; cfg_holdoff = 16'd5;
        cfg_rearm = 1'b1;
        out_ready = 1'b1;
        b0 = q_ts.size();
        arm_and_trigger(t0);
        k = 0;
        while (!st_done && k < 50) begin step(); k++; end
        check("rearm st_done seen", 64'(st_done), 1);
        // done observed, one clk to leave DRAIN, then 5 HOLDOFF clks
        k = 0;
        while (!st_armed && k < 50) begin step(); k++; end
        check("rearm clks to armed", 64'(k), 6);
        check("rearm beats", 64'(q_ts.size() - b0), 2);
        if (q_ts.size() - b0 >= 1) check("rearm beat0 ts", 64'(q_ts[b0]), 64'(t0 + 1));
        step(10);
        check("held trigger armed", 64'(st_armed), 1);
        check("held trigger busy", 64'(st_busy), 0);
        check("held trigger no beats", 64'(q_ts.size() - b0), 2);
        trigger_in = 1'b0;
        step();
        trigger_in = 1'b1;
        cfg_rearm = 1'b0;
        t0 = mono;
        step();
        trigger_in = 1'b0;
        k = 0;
        while ((st_busy || st_armed) && k < 100) begin step(); k++; end
        check("second burst beats", 64'(q_ts.size() - b0), 4);
        if (q_ts.size() - b0 >= 3) check("second burst ts", 64'(q_ts[b0+2]), 64'(t0 + 1));
        check("second burst ends idle", 64'(st_armed), 0);

        // abort in BURST with one entry buffered
        cfg_delay = '0; cfg_count = 16'd4; cfg_decim = 8'd3; cfg_holdoff = '0;
        out_ready = 1'b0;
        b0 = q_ts.size();
        d0 = done_cnt;
        arm_and_trigger(t0);
        trigger_in = 1'b0;
        step();
        check("abort pre valid", 64'(out_valid), 1);
        check("abort pre ts", 64'(out_ts), 64'(t0 + 1));
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        check("abort valid", 64'(out_valid), 0);
        check("abort busy", 64'(st_busy), 0);
        check("abort armed", 64'(st_armed), 0);
        out_ready = 1'b1;
        step(8);
        check("abort no done", 64'(done_cnt - d0), 0);
        check("abort no beats", 64'(q_ts.size() - b0), 0);

        // async reset mid-DELAY, then a normal burst
        cfg_delay = 16'd20; cfg_count = 16'd2; cfg_decim = '0;
        arm_and_trigger(t0);
        step(3);
        check("delay busy", 64'(st_busy), 1);
        #3 rst_n = 1'b0;
        #1 check_zero("mid-delay reset");
        step();
        rst_n = 1'b1;
        step();
        run_vec(vecs[0], "post-reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
